// File: rtl/usb_pkg.sv
// Types and constants shared by the USB bit stuffer and bit unstuffer.
package usb_pkg;

    localparam int STUFF_LEN_DEF = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STRIP = 2'd2,
        ERR   = 2'd3
    } stuff_state_t;

    function automatic int ones_cnt_width(input int stuff_len);
        return $clog2(stuff_len + 1);
    endfunction

endpackage

// File: rtl/bit_unstuff_ones_counter.sv
// Run-length counter of consecutive 1s; tc flags that this increment reaches STUFF_LEN.
module ones_counter
    import usb_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CW = ones_cnt_width(STUFF_LEN);

    logic [CW-1:0] cnt;

    // clr with inc restarts the run at one (a 1 that follows a broken run)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CW'(1) : '0;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = inc && !clr && (cnt == CW'(STUFF_LEN - 1));

endmodule

// File: rtl/bit_unstuff.sv
// USB receive bit unstuffer: drops the 0 that follows STUFF_LEN consecutive 1s.
// Define BIT_UNSTUFF_ERR_EN to flag a missing stuffed 0 and discard the rest of the packet.
module bit_unstuff
    import usb_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inb,
    input  logic recving,
    output logic outb,
    output logic out_valid,
    output logic stuff_err
);

    stuff_state_t state;
    logic         cnt_clr;
    logic         cnt_inc;
    logic         cnt_tc;

    ones_counter #(
        .STUFF_LEN (STUFF_LEN)
    ) u_ones_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .tc  (cnt_tc)
    );

    always_comb begin
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (!recving) begin
            cnt_clr = 1'b1;
        end else begin
            case (state)
                IDLE, RUN: begin
                    cnt_inc = inb;
                    cnt_clr = !inb;
                end
                STRIP: begin
                    cnt_clr = 1'b1;
`ifndef BIT_UNSTUFF_ERR_EN
                    // a violating 1 is kept as data and starts a new run
                    cnt_inc = inb;
`endif
                end
                default: begin
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

`ifdef BIT_UNSTUFF_ERR_EN
    logic err_pulse;
    assign stuff_err = err_pulse;
`else
    assign stuff_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            outb      <= 1'b1;
            out_valid <= 1'b0;
`ifdef BIT_UNSTUFF_ERR_EN
            err_pulse <= 1'b0;
`endif
        end else begin
`ifdef BIT_UNSTUFF_ERR_EN
            err_pulse <= 1'b0;
`endif
            if (!recving) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE, RUN: begin
                        outb      <= inb;
                        out_valid <= 1'b1;
                        state     <= cnt_tc ? STRIP : RUN;
                    end
                    STRIP: begin
                        if (!inb) begin
                            out_valid <= 1'b0;
                            state     <= RUN;
                        end else begin
`ifdef BIT_UNSTUFF_ERR_EN
                            err_pulse <= 1'b1;
                            out_valid <= 1'b0;
                            state     <= ERR;
`else
                            outb      <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= RUN;
`endif
                        end
                    end
`ifdef BIT_UNSTUFF_ERR_EN
                    ERR: begin
                        out_valid <= 1'b0;
                    end
`endif
                    default: begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
